// File: rtl/cdb_rr_scheduler.sv
// Registered round-robin CDB scheduler: one grant per cycle among a max-priority
// channel and N_REQ ordinary units, with aging so the ordinary units cannot starve.
module cdb_rr_scheduler #(
  parameter int N_REQ    = 5,
  parameter int MAX_WAIT = 8,
  parameter int SEL_W    = $clog2(N_REQ + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             max_prio_valid_i,
  output logic             max_prio_ready_o,
  input  logic [N_REQ-1:0] valid_i,
  output logic [N_REQ-1:0] ready_o,
  input  logic             rob_ready_i,
  output logic             rob_valid_o,
  output logic             served_max_prio_o,
  output logic [SEL_W-1:0] served_o
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int AGE_W = $clog2(MAX_WAIT + 1);

  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic             out_mp_q, out_mp_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [AGE_W-1:0] age_cnt_q, age_cnt_d;

  logic             adv, any_valid, force_ord, grant_ok, grant_mp, grant_rr;
  logic             rr_found;
  logic [PTR_W-1:0] rr_idx;
  int               cand;

  // NOTE: every signal driven here gets a default before any branch, otherwise
  // paths that skip an assignment would infer latches.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = 0;
    // First requester at or after the pointer, wrapping around the unit list.
    for (int i = 0; i < N_REQ; i++) begin
      cand = (int'(rr_ptr_q) + i) % N_REQ;
      if (!rr_found && valid_i[cand]) begin
        rr_found = 1'b1;
        rr_idx   = PTR_W'(cand);
      end
    end
  end

  always_comb begin
    adv       = !out_valid_q || rob_ready_i;
    any_valid = |valid_i;
    force_ord = (age_cnt_q == AGE_W'(MAX_WAIT)) && any_valid;
    grant_ok  = adv && !flush_i && !rst_i;
    grant_mp  = grant_ok && max_prio_valid_i && !force_ord;
    grant_rr  = grant_ok && !grant_mp && rr_found;

    max_prio_ready_o = grant_mp;
    ready_o          = grant_rr ? (N_REQ'(1) << rr_idx) : '0;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_sel_d   = out_sel_q;
    out_mp_d    = out_mp_q;
    rr_ptr_d    = rr_ptr_q;
    age_cnt_d   = age_cnt_q;

    if (flush_i) begin
      out_valid_d = 1'b0;
      age_cnt_d   = '0;
    end else if (adv) begin
      if (grant_mp) begin
        out_valid_d = 1'b1;
        out_sel_d   = '0;
        out_mp_d    = 1'b1;
      end else if (grant_rr) begin
        out_valid_d = 1'b1;
        out_sel_d   = SEL_W'(rr_idx) + SEL_W'(1);
        out_mp_d    = 1'b0;
        rr_ptr_d    = (rr_idx == PTR_W'(N_REQ - 1)) ? '0 : rr_idx + 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end

      // Age counts only the cycles in which max-priority wins over waiting units.
      if (grant_rr || !any_valid) begin
        age_cnt_d = '0;
      end else if (grant_mp && age_cnt_q != AGE_W'(MAX_WAIT)) begin
        age_cnt_d = age_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
      out_mp_q    <= 1'b0;
      rr_ptr_q    <= '0;
      age_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      out_mp_q    <= out_mp_d;
      rr_ptr_q    <= rr_ptr_d;
      age_cnt_q   <= age_cnt_d;
    end
  end

  assign rob_valid_o       = out_valid_q;
  assign served_o          = out_sel_q;
  assign served_max_prio_o = out_mp_q;

endmodule

// File: tb/tb_cdb_rr_scheduler.sv
// Directed bench for cdb_rr_scheduler: stimulus pushes expected CDB selects into a
// scoreboard queue, a monitor pops and compares on every ROB accept.
module tb_cdb_rr_scheduler;

  localparam int N_REQ = 5;
  localparam int SEL_W = 3;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             flush_i = 1'b0;
  logic             max_prio_valid_i = 1'b0;
  logic             max_prio_ready_o;
  logic [N_REQ-1:0] valid_i = '0;
  logic [N_REQ-1:0] ready_o;
  logic             rob_ready_i = 1'b0;
  logic             rob_valid_o;
  logic             served_max_prio_o;
  logic [SEL_W-1:0] served_o;

  int errors = 0;
  int checks = 0;
  int sb[$];

  cdb_rr_scheduler #(.N_REQ(N_REQ), .MAX_WAIT(8)) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .flush_i           (flush_i),
    .max_prio_valid_i  (max_prio_valid_i),
    .max_prio_ready_o  (max_prio_ready_o),
    .valid_i           (valid_i),
    .ready_o           (ready_o),
    .rob_ready_i       (rob_ready_i),
    .rob_valid_o       (rob_valid_o),
    .served_max_prio_o (served_max_prio_o),
    .served_o          (served_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive just after the rising edge, check the
  // combinational readies at the falling edge, and log any expected grant.
  task automatic cycle(input logic rst, input logic fl, input logic mp,
                       input logic [N_REQ-1:0] v, input logic rr,
                       input logic [N_REQ-1:0] exp_rdy, input logic exp_mpr,
                       input string name);
    @(posedge clk);
    #1;
    rst_i = rst; flush_i = fl; max_prio_valid_i = mp; valid_i = v; rob_ready_i = rr;
    @(negedge clk);
    check({name, ".ready"}, 32'(ready_o), 32'(exp_rdy));
    check({name, ".mp_ready"}, 32'(max_prio_ready_o), 32'(exp_mpr));
    if (exp_mpr) sb.push_back(0);
    else begin
      for (int k = 0; k < N_REQ; k++)
        if (exp_rdy[k]) sb.push_back(k + 1);
    end
  endtask

  // Monitor: every ROB accept must match the oldest outstanding expected grant.
  always @(negedge clk) begin
    if (!rst_i && rob_valid_o && rob_ready_i) begin
      if (sb.size() == 0) begin
        check("mon.unexpected_accept", 32'(served_o), 32'hFFFF_FFFF);
      end else begin
        int exp_sel;
        exp_sel = sb.pop_front();
        check("mon.served", 32'(served_o), 32'(exp_sel));
        check("mon.served_mp", 32'(served_max_prio_o), 32'(exp_sel == 0));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with every requester active.
    rst_i = 1'b1; max_prio_valid_i = 1'b1; valid_i = 5'b11111;
    for (int i = 0; i < 2; i++) begin
      cycle(1, 0, 1, 5'b11111, 1, 5'b00000, 0, "reset");
      check("reset.rob_valid", 32'(rob_valid_o), 0);
      check("reset.served", 32'(served_o), 0);
    end
    cycle(0, 0, 1, 5'b11111, 1, 5'b00000, 1, "release");

    // Round robin across all units with wrap 4 -> 0.
    cycle(0, 0, 0, 5'b11111, 1, 5'b00001, 0, "rr0");
    check("release.rob_valid", 32'(rob_valid_o), 1);
    cycle(0, 0, 0, 5'b11111, 1, 5'b00010, 0, "rr1");
    cycle(0, 0, 0, 5'b11111, 1, 5'b00100, 0, "rr2");
    cycle(0, 0, 0, 5'b11111, 1, 5'b01000, 0, "rr3");
    cycle(0, 0, 0, 5'b11111, 1, 5'b10000, 0, "rr4");
    cycle(0, 0, 0, 5'b11111, 1, 5'b00001, 0, "rr_wrap0");
    cycle(0, 0, 0, 5'b11111, 1, 5'b00010, 0, "rr_wrap1");

    // Aging: eight max-priority wins over unit 2, then unit 2 is forced.
    for (int i = 0; i < 8; i++)
      cycle(0, 0, 1, 5'b00100, 1, 5'b00000, 1, "age_mp");
    cycle(0, 0, 1, 5'b00100, 1, 5'b00100, 0, "age_force");
    cycle(0, 0, 1, 5'b00100, 1, 5'b00000, 1, "age_restart");
    cycle(0, 0, 0, 5'b00000, 1, 5'b00000, 0, "age_idle");

    // Backpressure: unit 1 granted (search starts at 3), then ROB stalls.
    cycle(0, 0, 0, 5'b00010, 1, 5'b00010, 0, "bp_grant");
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 5'b11111, 0, 5'b00000, 0, "bp_stall");
      check("bp.rob_valid", 32'(rob_valid_o), 1);
      check("bp.served", 32'(served_o), 2);
    end
    cycle(0, 0, 1, 5'b11111, 1, 5'b00000, 1, "bp_release");

    // Flush with unit 3 in the output register and the pointer at 4.
    cycle(0, 0, 0, 5'b01000, 1, 5'b01000, 0, "fl_setup");
    cycle(0, 1, 1, 5'b11111, 0, 5'b00000, 0, "flush");
    check("flush.rob_valid", 32'(rob_valid_o), 1);
    check("flush.served", 32'(served_o), 4);
    if (sb.size() > 0) void'(sb.pop_back());
    cycle(0, 0, 0, 5'b11111, 1, 5'b10000, 0, "post_flush");
    check("post_flush.rob_valid", 32'(rob_valid_o), 0);

    // Idle: register drains, pointer (now 0) is unchanged by idle cycles.
    cycle(0, 0, 0, 5'b00000, 1, 5'b00000, 0, "idle0");
    cycle(0, 0, 0, 5'b00000, 1, 5'b00000, 0, "idle1");
    check("idle.rob_valid", 32'(rob_valid_o), 0);
    cycle(0, 0, 0, 5'b11111, 1, 5'b00001, 0, "idle_ptr");
    cycle(0, 0, 0, 5'b00000, 1, 5'b00000, 0, "drain0");
    cycle(0, 0, 0, 5'b00000, 1, 5'b00000, 0, "drain1");
    check("drain.rob_valid", 32'(rob_valid_o), 0);
    check("drain.scoreboard_empty", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
